// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, baud constant and
// frame helper functions.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int UART_CLKS_460800 = 109;

   function automatic int frame_len(input int data_bits, input int parity_en, input int stop_bits);
      return 1 + data_bits + parity_en + stop_bits;
   endfunction

   // Zero padding above the word does not change the XOR result.
   function automatic logic parity9(input logic [8:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit. Shared between the UART transmitter and receiver.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 109
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ONE      = CW'(1'b1);

   logic [CW-1:0] cnt_r;

   assign bit_end = enable && (cnt_r == LAST_CNT);

   // Baud counter, restarted on clear and at every bit boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (clear || !enable || (cnt_r == LAST_CNT)) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_r + ONE;
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity and one or two stop bits, fed by a valid/ready handshake.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_460800,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 CLOCK_50,
   input  logic                 Reset,
   input  logic [DATA_BITS-1:0] Tx_Data,
   input  logic                 Tx_Valid,
   output logic                 Tx_Ready,
   output logic                 Serial_Data,
   output logic                 Busy
);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
      $error("uart_tx_param: illegal parameter combination");
   end

   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1'b1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_e          state_r, state_s;
   logic [DATA_BITS-1:0] shreg_r, shreg_s;
   logic                 par_r, par_s;
   logic [BW-1:0]        bit_cnt_r, bit_cnt_s;
   logic                 stop_cnt_r, stop_cnt_s;
   logic                 serial_r, serial_s;
   logic                 ready_r, busy_r;
   logic                 handshake_s, bit_end_s;

   assign handshake_s = Tx_Valid && ready_r;
   assign Tx_Ready    = ready_r;
   assign Serial_Data = serial_r;
   assign Busy        = busy_r;

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (CLOCK_50),
      .rst     (Reset),
      .clear   (handshake_s),
      .enable  (state_r != IDLE),
      .bit_end (bit_end_s)
   );

   // Next-state, shift register, counters and the line level for the next cycle.
   always_comb begin
      state_s    = state_r;
      shreg_s    = shreg_r;
      par_s      = par_r;
      bit_cnt_s  = bit_cnt_r;
      stop_cnt_s = stop_cnt_r;
      case (state_r)
         IDLE: begin
            if (handshake_s) begin
               shreg_s    = Tx_Data;
               par_s      = parity9(9'(Tx_Data), PARITY_ODD != 0);
               bit_cnt_s  = {BW{1'b0}};
               stop_cnt_s = 1'b0;
               state_s    = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) state_s = DATA;
            else           state_s = START;
         end
         DATA: begin
            if (bit_end_s) begin
               shreg_s = {1'b0, shreg_r[DATA_BITS-1:1]};
               if (bit_cnt_r == LAST_BIT) begin
                  bit_cnt_s = {BW{1'b0}};
                  state_s   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_s = bit_cnt_r + BIT_ONE;
               end
            end else begin
               state_s = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) state_s = STOP;
            else           state_s = PARITY;
         end
         STOP: begin
            if (bit_end_s) begin
               if (stop_cnt_r == LAST_STOP) begin
                  stop_cnt_s = 1'b0;
                  state_s    = IDLE;
               end else begin
                  stop_cnt_s = stop_cnt_r + 1'b1;
               end
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s    = IDLE;
            bit_cnt_s  = {BW{1'b0}};
            stop_cnt_s = 1'b0;
         end
      endcase

      // Line level follows the state being entered so the output can be registered.
      case (state_s)
         IDLE:    serial_s = 1'b1;
         START:   serial_s = 1'b0;
         DATA:    serial_s = shreg_s[0];
         PARITY:  serial_s = par_s;
         STOP:    serial_s = 1'b1;
         default: serial_s = 1'b1;
      endcase
   end

   // State and datapath registers; outputs registered from the next state.
   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         state_r    <= IDLE;
         shreg_r    <= {DATA_BITS{1'b0}};
         par_r      <= 1'b0;
         bit_cnt_r  <= {BW{1'b0}};
         stop_cnt_r <= 1'b0;
         serial_r   <= 1'b1;
         ready_r    <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         shreg_r    <= shreg_s;
         par_r      <= par_s;
         bit_cnt_r  <= bit_cnt_s;
         stop_cnt_r <= stop_cnt_s;
         serial_r   <= serial_s;
         ready_r    <= (state_s == IDLE);
         busy_r     <= (state_s != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed scoreboard bench for uart_tx_param across four parameter sets.
module tb_uart_tx_param;

   logic       CLOCK_50 = 1'b0;
   logic       Reset;
   logic [8:0] data_v [4];
   logic [3:0] valid_v;
   wire  [3:0] sd, rdy, bsy;
   int         checks = 0;
   int         errors = 0;
   bit         exp_q[$];
   int         w;

   always #10 CLOCK_50 = ~CLOCK_50;

   uart_tx_param u0 (
      .CLOCK_50(CLOCK_50), .Reset(Reset), .Tx_Data(data_v[0][7:0]), .Tx_Valid(valid_v[0]),
      .Tx_Ready(rdy[0]), .Serial_Data(sd[0]), .Busy(bsy[0]));

   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
      .CLOCK_50(CLOCK_50), .Reset(Reset), .Tx_Data(data_v[1][6:0]), .Tx_Valid(valid_v[1]),
      .Tx_Ready(rdy[1]), .Serial_Data(sd[1]), .Busy(bsy[1]));

   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u2 (
      .CLOCK_50(CLOCK_50), .Reset(Reset), .Tx_Data(data_v[2][7:0]), .Tx_Valid(valid_v[2]),
      .Tx_Ready(rdy[2]), .Serial_Data(sd[2]), .Busy(bsy[2]));

   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) u3 (
      .CLOCK_50(CLOCK_50), .Reset(Reset), .Tx_Data(data_v[3][7:0]), .Tx_Valid(valid_v[3]),
      .Tx_Ready(rdy[3]), .Serial_Data(sd[3]), .Busy(bsy[3]));

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Expected line bits for one frame, built from the word and the framing.
   task automatic push_frame(input logic [8:0] d, input int nd, input bit pen, input bit podd,
                             input int ns);
      bit p;
      p = podd;
      exp_q.push_back(1'b0);
      for (int i = 0; i < nd; i++) begin
         exp_q.push_back(d[i]);
         p = p ^ d[i];
      end
      if (pen) exp_q.push_back(p);
      for (int i = 0; i < ns; i++) exp_q.push_back(1'b1);
   endtask

   // Called just after a falling edge; returns just after the handshake edge.
   task automatic start_word(input int s, input logic [8:0] d, output int waits);
      data_v[s]  = d;
      valid_v[s] = 1'b1;
      waits      = 0;
      while (rdy[s] !== 1'b1 && waits < 5000) begin
         @(negedge CLOCK_50);
         waits++;
      end
      chk("handshake_wait", rdy[s], 1'b1);
      @(posedge CLOCK_50);
   endtask

   // mode 0: keep valid/data; 1: drop valid; 2: drop valid, scramble data; 3: pulse valid.
   task automatic check_frame(input int s, input int clks, input int mode, input string tag);
      bit b;
      int k;
      k = 0;
      while (exp_q.size() > 0) begin
         b = exp_q.pop_front();
         for (int c = 0; c < clks; c++) begin
            @(negedge CLOCK_50);
            if (mode != 0 && k == 0) valid_v[s] = 1'b0;
            if (mode == 2) data_v[s] = 9'($urandom);
            if (mode == 3) valid_v[s] = 1'($urandom);
            chk({tag, "_line"}, sd[s], b);
            chk({tag, "_busy"}, bsy[s], 1'b1);
            chk({tag, "_ready"}, rdy[s], 1'b0);
            k++;
         end
      end
      @(negedge CLOCK_50);
      if (mode != 0) valid_v[s] = 1'b0;
      chk({tag, "_end_line"}, sd[s], 1'b1);
      chk({tag, "_end_busy"}, bsy[s], 1'b0);
      chk({tag, "_end_ready"}, rdy[s], 1'b1);
   endtask

   task automatic idle_check(input int s, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge CLOCK_50);
         chk({tag, "_line"}, sd[s], 1'b1);
         chk({tag, "_busy"}, bsy[s], 1'b0);
      end
   endtask

   initial begin
      Reset   = 1'b1;
      valid_v = 4'b0000;
      for (int i = 0; i < 4; i++) data_v[i] = 9'h000;
      repeat (2) @(negedge CLOCK_50);
      for (int i = 0; i < 4; i++) begin
         chk("rst_line", sd[i], 1'b1);
         chk("rst_ready", rdy[i], 1'b1);
         chk("rst_busy", bsy[i], 1'b0);
      end
      Reset = 1'b0;
      @(negedge CLOCK_50);

      // Default framing, 109 cycles per bit.
      push_frame(9'h0A5, 8, 1'b0, 1'b0, 1);
      start_word(0, 9'h0A5, w);
      check_frame(0, 109, 1, "a5");

      // Parity cases.
      push_frame(9'h035, 7, 1'b1, 1'b1, 1);
      start_word(1, 9'h035, w);
      check_frame(1, 4, 1, "par_odd_35");
      push_frame(9'h007, 8, 1'b1, 1'b0, 1);
      start_word(2, 9'h007, w);
      check_frame(2, 4, 1, "par_even_07");

      // Back-to-back with valid held high and two stop bits.
      push_frame(9'h000, 8, 1'b0, 1'b0, 2);
      start_word(3, 9'h000, w);
      check_frame(3, 4, 0, "b2b_00");
      push_frame(9'h0FF, 8, 1'b0, 1'b0, 2);
      start_word(3, 9'h0FF, w);
      chk("b2b_gap1", w == 0, 1'b1);
      check_frame(3, 4, 0, "b2b_ff");
      push_frame(9'h03C, 8, 1'b0, 1'b0, 2);
      start_word(3, 9'h03C, w);
      chk("b2b_gap2", w == 0, 1'b1);
      check_frame(3, 4, 1, "b2b_3c");
      idle_check(3, 60, "b2b_idle");

      // Data changing after the handshake, then valid pulsing while busy.
      push_frame(9'h05A, 8, 1'b0, 1'b0, 1);
      start_word(0, 9'h05A, w);
      check_frame(0, 109, 2, "scramble_5a");
      push_frame(9'h096, 8, 1'b0, 1'b0, 1);
      start_word(0, 9'h096, w);
      check_frame(0, 109, 3, "pulse_96");
      idle_check(0, 250, "pulse_idle");

      // Reset during the fourth data bit of 0xC3 (that bit is 0).
      start_word(0, 9'h0C3, w);
      @(negedge CLOCK_50);
      valid_v[0] = 1'b0;
      repeat (4 * 109 + 40) @(negedge CLOCK_50);
      chk("pre_reset_line", sd[0], 1'b0);
      #1 Reset = 1'b1;
      #1;
      chk("mid_reset_line", sd[0], 1'b1);
      chk("mid_reset_ready", rdy[0], 1'b1);
      chk("mid_reset_busy", bsy[0], 1'b0);
      repeat (2) @(negedge CLOCK_50);
      Reset = 1'b0;
      idle_check(0, 250, "post_reset_idle");
      push_frame(9'h081, 8, 1'b0, 1'b0, 1);
      start_word(0, 9'h081, w);
      check_frame(0, 109, 1, "after_reset_81");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the successor to the fixed 8N1 / 460800-baud transmitter in the serial audio path. It accepts words over a valid/ready handshake and serialises each one as start, data (LSB first), optional parity and one or two stop bits. Bit period, data width and framing are parameters. It sits between the audio sample packer and the FPGA TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 109: CLOCK_50 cycles per bit (50 MHz / 460800 ≈ 108.5, rounded up); legal ≥ 2.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits; legal 1 or 2.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Tx_Data  in  DATA_BITS  word to send; sampled only on handshake.
- Tx_Valid  in  1  Tx_Data is valid.
- Tx_Ready  out  1  block can accept a word (IDLE only).
- Serial_Data  out  1  UART line, registered; idles high.
- Busy  out  1  high from the handshake until the end of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Serial_Data is 1, 0, shreg[0], par and 1 respectively.
- IDLE: Tx_Ready = 1. When Tx_Valid && Tx_Ready at an edge:
  - latch Tx_Data into shreg;
  - compute par = ^Tx_Data ^ PARITY_ODD;
  - clear the baud and bit counters;
  - go to START.
- Baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state; bit_end = (count == CLKS_PER_BIT-1).
- START: on bit_end, go to DATA.
- DATA: on bit_end, shift shreg right and increment the bit counter. After DATA_BITS bits, go to PARITY if PARITY_EN, otherwise STOP.
- PARITY: on bit_end, go to STOP.
- STOP: on bit_end with stop counter = STOP_BITS-1, go to IDLE; otherwise increment the stop counter.
- Tx_Data changes after the handshake have no effect on the frame in flight.
- Tx_Valid while not ready is held off. No word is dropped or duplicated; a valid held across IDLE produces exactly one frame per handshake.
- Unused or illegal state encodings return to IDLE on the next edge with Serial_Data = 1.
- Out-of-range parameters are caught by an elaboration-time check ($error), never by silent clamping.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream): state = IDLE, Serial_Data = 1, Tx_Ready = 1, Busy = 0, all counters 0, shreg 0.
- Reset mid-frame aborts the frame; the line goes high immediately and no partial frame resumes.
- Handshake at edge N: Serial_Data falls after edge N; Tx_Ready = 0 and Busy = 1 from edge N.
- Every bit holds for exactly CLKS_PER_BIT cycles.
- Frame length F = (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- At edge N+F: state = IDLE, Busy = 0, Tx_Ready = 1.
- The earliest next handshake is edge N+F+1. Back-to-back frame period is F+1 cycles; the extra cycle is an idle-high extension of the stop bit.
- Counter widths: baud $clog2(CLKS_PER_BIT), data-bit $clog2(DATA_BITS+1), stop-bit 1. Counters never wrap inside a bit; they are cleared on every bit_end.

## Structure
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding;
  - localparam UART_CLKS_460800 = 109;
  - function frame_len(DATA_BITS, PARITY_EN, STOP_BITS).
- Sub-module uart_baud_tick (CLKS_PER_BIT parameter): inputs clear/enable, output bit_end pulse. It replaces the fixed-period timer and is reused by the planned RX.
- Shift register and parity are inline; no separate PISO instance.

## Test plan
- Default parameters, send 0xA5: line reads 0, 1,0,1,0,0,1,0,1, then 1, each held 109 cycles. Busy is high for 1090 cycles and Tx_Ready returns at edge N+1090.
- DATA_BITS = 7, PARITY_EN = 1, PARITY_ODD = 1, send 0x35 (four ones): parity bit = 1. DATA_BITS = 8, PARITY_ODD = 0, send 0x07: parity bit = 1.
- STOP_BITS = 2, CLKS_PER_BIT = 4, Tx_Valid held high with data 0x00, 0xFF, 0x3C: three frames, each period 4×11+1 = 45 cycles, with no lost or duplicated word.
- Change Tx_Data every cycle after the handshake: the transmitted frame matches the handshake-time value.
- Assert Reset during the fourth data bit: Serial_Data = 1 and Tx_Ready = 1 immediately. After release, a new 0x81 frame transmits cleanly.
- Check Tx_Valid pulsing while Busy = 1: no handshake occurs and the line waveform is unchanged.
